// File: rtl/ahb_gpio_slave.sv
// AHB-Lite responder for board I/O: switches, LEDs, RGB and a scanned 8-digit 7-segment display.
// Zero-wait OKAY transfers; two-cycle ERROR response for illegal accesses.
module ahb_gpio_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic [15:0]           SW,
  output logic [15:0]           LED,
  output logic [5:0]            RGB,
  output logic [7:0]            SEG,
  output logic [7:0]            EN_7SEG
);

  localparam int CW = $clog2(SCAN_DIV);

  logic        valid_q, write_q, err2_q;
  logic [4:0]  off_q;
  logic [2:0]  size_q;
  logic [15:0] led_q, ctrl_q, sw_meta_q, sw_sync_q;
  logic [5:0]  rgb_q;
  logic [31:0] hex_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  seg_q, en_q;

  logic accept, bad, err_now, ok, wr;
  logic [3:0]  be;
  logic [31:0] rd_sel, led_m, rgb_m, hex_m, ctrl_m;
  logic [15:0] led_d, ctrl_d;
  logic [5:0]  rgb_d;
  logic [31:0] hex_d;
  logic [3:0]  nib;
  logic [7:0]  seg_d, en_d;

  logic unused;
  assign unused = ^{HADDR[ADDR_WIDTH-1:5], HTRANS[0]};

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] lanes);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign accept = HSEL & HREADY & HTRANS[1];

  // Decoded from the latched address phase, so it is valid during the whole data phase.
  assign bad = (off_q[4:2] > 3'd4) || (size_q > 3'd2) ||
               (size_q == 3'd1 && off_q[0]) ||
               (size_q == 3'd2 && off_q[1:0] != 2'b00) ||
               (write_q && off_q[4:2] == 3'd0);
  assign err_now = valid_q & bad;
  assign ok      = valid_q & ~bad;
  assign wr      = ok & write_q;

  assign HREADYOUT = ~err_now;
  assign HRESP     = err_now | err2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      off_q   <= 5'd0;
      size_q  <= 3'd0;
      err2_q  <= 1'b0;
    end else begin
      valid_q <= accept;
      err2_q  <= err_now;
      if (accept) begin
        off_q   <= HADDR[4:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be = 4'b0001 << off_q[1:0];
      3'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    led_m  = merge({16'h0, led_q}, HWDATA, be);
    rgb_m  = merge({26'h0, rgb_q}, HWDATA, be);
    hex_m  = merge(hex_q, HWDATA, be);
    ctrl_m = merge({16'h0, ctrl_q}, HWDATA, be);
    led_d  = led_q;
    rgb_d  = rgb_q;
    hex_d  = hex_q;
    ctrl_d = ctrl_q;
    if (wr) begin
      case (off_q[4:2])
        3'd1:    led_d  = led_m[15:0];
        3'd2:    rgb_d  = rgb_m[5:0];
        3'd3:    hex_d  = hex_m;
        3'd4:    ctrl_d = ctrl_m[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_q     <= 16'h0;
      rgb_q     <= 6'h0;
      hex_q     <= 32'h0;
      ctrl_q    <= 16'h00FF;
      sw_meta_q <= 16'h0;
      sw_sync_q <= 16'h0;
    end else begin
      led_q     <= led_d;
      rgb_q     <= rgb_d;
      hex_q     <= hex_d;
      ctrl_q    <= ctrl_d;
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_comb begin
    rd_sel = 32'h0;
    case (off_q[4:2])
      3'd0:    rd_sel = {16'h0, sw_sync_q};
      3'd1:    rd_sel = {16'h0, led_q};
      3'd2:    rd_sel = {26'h0, rgb_q};
      3'd3:    rd_sel = hex_q;
      3'd4:    rd_sel = {16'h0, ctrl_q};
      default: rd_sel = 32'h0;
    endcase
  end

  assign HRDATA = (ok && !write_q) ? rd_sel : '0;
  assign LED    = led_q;
  assign RGB    = rgb_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      idx_q <= 3'd0;
    end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    nib   = hex_q[{idx_q, 2'b00} +: 4];
    en_d  = ctrl_q[idx_q] ? ~(8'd1 << idx_q) : 8'hFF;
    seg_d = {~ctrl_q[{1'b1, idx_q}], glyph(nib)};
  end

  // Reset values match what the decode produces for HEX=0, CTRL=0x00FF, digit 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg_q <= 8'hC0;
      en_q  <= 8'hFE;
    end else begin
      seg_q <= seg_d;
      en_q  <= en_d;
    end
  end

  assign SEG     = seg_q;
  assign EN_7SEG = en_q;

endmodule

// File: tb/tb_ahb_gpio_slave.sv
// Directed bench for ahb_gpio_slave: register access, byte lanes, errors, switches and scanner.
module tb_ahb_gpio_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout, hresp;
  logic [15:0] sw, led;
  logic [5:0]  rgb;
  logic [7:0]  seg, en;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] glyph_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  assign hready = hreadyout;
  always #5 clk = ~clk;

  ahb_gpio_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .SCAN_DIV  (4)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .HSEL     (hsel),
    .HADDR    (haddr),
    .HTRANS   (htrans),
    .HWRITE   (hwrite),
    .HSIZE    (hsize),
    .HWDATA   (hwdata),
    .HREADY   (hready),
    .HRDATA   (hrdata),
    .HREADYOUT(hreadyout),
    .HRESP    (hresp),
    .SW       (sw),
    .LED      (led),
    .RGB      (rgb),
    .SEG      (seg),
    .EN_7SEG  (en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer; returns read data and response seen in first/last data cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits,
                      output logic resp_first, output logic resp_last);
    @(posedge clk); #1;
    hsel = 1'b1; haddr = addr; htrans = 2'd2; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = wd;
    waits = 0;
    @(negedge clk);
    resp_first = hresp;
    while (!hreadyout && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    resp_last = hresp;
    rd = hrdata;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wd);
    logic [31:0] rd; int w; logic r1, r2;
    xfer(1'b1, addr, size, wd, rd, w, r1, r2);
    check({tag, "_waits"}, w, 0);
    check({tag, "_resp"}, {r1, r2}, 0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd; int w; logic r1, r2;
    xfer(1'b0, addr, 3'd2, 32'h0, rd, w, r1, r2);
    check({tag, "_waits"}, w, 0);
    check({tag, "_resp"}, {r1, r2}, 0);
    check(tag, rd, exp);
  endtask

  task automatic do_err(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size);
    logic [31:0] rd; int w; logic r1, r2;
    xfer(wr, addr, size, 32'hFFFF_FFFF, rd, w, r1, r2);
    check({tag, "_waits"}, w, 1);
    check({tag, "_resp"}, {r1, r2}, 2'b11);
  endtask

  initial begin
    int cnt_fe, cnt_ff;
    logic [7:0] exp_en, seg_at_fe;

    rst = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = 2'd0; hwrite = 1'b0;
    hsize = 3'd2; hwdata = 32'h0; sw = 16'h0;
    #1;
    check("rst_hreadyout", hreadyout, 1);
    check("rst_hresp", hresp, 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_led", led, 0);
    check("rst_en", en, 8'hFE);
    check("rst_seg", seg, 8'hC0);
    #20;
    @(negedge clk); rst = 1'b0;

    do_read("rd_led0", 32'h04, 32'h0);
    do_read("rd_rgb0", 32'h08, 32'h0);
    do_read("rd_hex0", 32'h0C, 32'h0);
    do_read("rd_ctrl0", 32'h10, 32'h00FF);

    do_write("wr_led", 32'h04, 3'd2, 32'hDEAD_BEEF);
    do_read("rd_led", 32'h04, 32'h0000_BEEF);
    check("led_port", led, 16'hBEEF);
    do_write("wr_rgb", 32'h08, 3'd2, 32'hFFFF_FFC5);
    do_read("rd_rgb", 32'h08, 32'h0000_0005);
    check("rgb_port", rgb, 6'h05);
    do_write("wr_hexb1", 32'h0D, 3'd0, 32'h0000_A500);
    do_read("rd_hexb1", 32'h0C, 32'h0000_A500);
    do_write("wr_ledb1", 32'h05, 3'd0, 32'h0000_1200);
    do_read("rd_ledb1", 32'h04, 32'h0000_12EF);

    // Write HEX, then read it in the overlapping address phase.
    @(posedge clk); #1;
    hsel = 1'b1; haddr = 32'h0C; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'h7654_3210; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0;
    @(negedge clk);
    check("b2b_rdata", hrdata, 32'h7654_3210);
    check("b2b_ok", {hreadyout, hresp}, 2'b10);

    for (int i = 0; i < 40 && en !== 8'hFD; i++) @(negedge clk);
    check("scan_en1", en, 8'hFD);
    check("scan_seg1", seg, 8'hF9);
    for (int d = 2; d <= 8; d++) begin
      repeat (4) @(negedge clk);
      exp_en = ~(8'd1 << (d % 8));
      check($sformatf("scan_en%0d", d % 8), en, exp_en);
      check($sformatf("scan_seg%0d", d % 8), seg, glyph_tab[d % 8]);
    end

    do_err("err_wr_sw", 1'b1, 32'h00, 3'd2);
    do_err("err_rd_14", 1'b0, 32'h14, 3'd2);
    do_err("err_misalign", 1'b0, 32'h06, 3'd2);
    do_err("err_size3", 1'b0, 32'h04, 3'd3);
    do_read("rd_led_after_err", 32'h04, 32'h0000_12EF);
    do_read("rd_sw0", 32'h00, 32'h0);

    @(posedge clk); #3;
    sw = 16'h1234;
    repeat (3) @(posedge clk);
    do_read("rd_sw", 32'h00, 32'h0000_1234);

    do_write("wr_ctrl", 32'h10, 3'd2, 32'h0000_0101);
    repeat (3) @(negedge clk);
    cnt_fe = 0; cnt_ff = 0; seg_at_fe = 8'h00;
    for (int i = 0; i < 32; i++) begin
      if (en == 8'hFE) begin cnt_fe++; seg_at_fe = seg; end
      if (en == 8'hFF) cnt_ff++;
      @(negedge clk);
    end
    check("ctrl_cnt_fe", cnt_fe, 4);
    check("ctrl_cnt_ff", cnt_ff, 28);
    check("ctrl_seg_dp", seg_at_fe, 8'h40);

    // Reset asserted in the first ERROR cycle must clear everything without a clock edge.
    @(posedge clk); #1;
    hsel = 1'b1; haddr = 32'h00; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0;
    #1;
    check("mid_err_hreadyout", hreadyout, 0);
    rst = 1'b1;
    #1;
    check("rst_err_hreadyout", hreadyout, 1);
    check("rst_err_hresp", hresp, 0);
    check("rst_err_led", led, 0);
    check("rst_err_rgb", rgb, 0);
    check("rst_err_en", en, 8'hFE);
    check("rst_err_seg", seg, 8'hC0);
    @(negedge clk); rst = 1'b0;
    do_read("rd_hex_rst", 32'h0C, 32'h0);
    do_read("rd_ctrl_rst", 32'h10, 32'h00FF);
    do_read("rd_led_rst", 32'h04, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
